// File: rtl/vga_sync_pulse_gen_pkg.sv
// Shared VGA timing constants and types for the pulse generator and sync-porch stage.
// Defaults describe 640x480 at a 800x525 total raster.
package vga_sync_pulse_gen_pkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned H_ACTIVE      = 640;
  localparam int unsigned H_FRONT_PORCH = 18;
  localparam int unsigned H_BACK_PORCH  = 50;
  localparam int unsigned H_SYNC_PULSE  = 92;
  localparam int unsigned H_TOTAL       = H_ACTIVE + H_FRONT_PORCH + H_BACK_PORCH + H_SYNC_PULSE;

  localparam int unsigned V_ACTIVE      = 480;
  localparam int unsigned V_FRONT_PORCH = 10;
  localparam int unsigned V_BACK_PORCH  = 33;
  localparam int unsigned V_SYNC_PULSE  = 2;
  localparam int unsigned V_TOTAL       = V_ACTIVE + V_FRONT_PORCH + V_BACK_PORCH + V_SYNC_PULSE;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic h_sync;
    logic v_sync;
    logic frame_start;
  } sync_flags_t;

  // Last valid index of a modulo-total counter.
  function automatic cnt_t last_index(input int unsigned total);
    return CNT_W'(total - 1);
  endfunction

endpackage

// File: rtl/vga_sync_pulse_gen_if.sv
// Enable and timing outputs of the VGA sync pulse generator.
// master: the generator; slave: the downstream sync-porch stage / driver of enable.
interface vga_sync_pulse_gen_if;
  import vga_sync_pulse_gen_pkg::*;

  logic i_Enable;
  logic o_H_Sync;
  logic o_V_Sync;
  cnt_t o_Col_Count;
  cnt_t o_Row_Count;
  logic o_Frame_Start;

  modport master (
    input  i_Enable,
    output o_H_Sync, o_V_Sync, o_Col_Count, o_Row_Count, o_Frame_Start
  );

  modport slave (
    output i_Enable,
    input  o_H_Sync, o_V_Sync, o_Col_Count, o_Row_Count, o_Frame_Start
  );
endinterface

// File: rtl/vga_wrap_counter.sv
// Modulo-MODULO counter with enable; exposes its next value and a wrap flag so a
// parent can register derived outputs in lock-step with the count.
module vga_wrap_counter
  import vga_sync_pulse_gen_pkg::*;
#(
  parameter int unsigned MODULO = H_TOTAL
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic en,
  output cnt_t count,
  output logic wrap_c,
  output cnt_t next_c
);

  always_comb begin
    wrap_c = en && (count == last_index(MODULO));
    next_c = count;
    if (wrap_c) begin
      next_c = '0;
    end else if (en) begin
      next_c = count + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= next_c;
    end
  end

endmodule

// File: rtl/vga_sync_pulse_gen.sv
// Raster column/row counters with active-region flags and a frame-start strobe.
// Flags are registered from the counters' next values so they never skew against the counts.
module vga_sync_pulse_gen
  import vga_sync_pulse_gen_pkg::*;
#(
  parameter int unsigned TOTAL_COLS  = H_TOTAL,
  parameter int unsigned TOTAL_ROWS  = V_TOTAL,
  parameter int unsigned ACTIVE_COLS = H_ACTIVE,
  parameter int unsigned ACTIVE_ROWS = V_ACTIVE
) (
  input  logic                 CLK,
  input  logic                 i_Rst_L,
  vga_sync_pulse_gen_if.master bus
);

  cnt_t        col_q;
  cnt_t        row_q;
  cnt_t        col_next_c;
  cnt_t        row_next_c;
  logic        col_wrap_c;
  logic        row_wrap_c;
  sync_flags_t flags_q;
  sync_flags_t flags_next_c;

  vga_wrap_counter #(.MODULO(TOTAL_COLS)) u_col_cnt (
    .CLK    (CLK),
    .rst_n  (i_Rst_L),
    .en     (bus.i_Enable),
    .count  (col_q),
    .wrap_c (col_wrap_c),
    .next_c (col_next_c)
  );

  // Row advances only when the column wraps.
  vga_wrap_counter #(.MODULO(TOTAL_ROWS)) u_row_cnt (
    .CLK    (CLK),
    .rst_n  (i_Rst_L),
    .en     (col_wrap_c),
    .count  (row_q),
    .wrap_c (row_wrap_c),
    .next_c (row_next_c)
  );

  always_comb begin
    flags_next_c             = '0;
    flags_next_c.h_sync      = (col_next_c < CNT_W'(ACTIVE_COLS));
    flags_next_c.v_sync      = (row_next_c < CNT_W'(ACTIVE_ROWS));
    flags_next_c.frame_start = row_wrap_c;
  end

  always_ff @(posedge CLK or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      flags_q <= '{h_sync: 1'b1, v_sync: 1'b1, frame_start: 1'b0};
    end else begin
      flags_q <= flags_next_c;
    end
  end

  assign bus.o_Col_Count   = col_q;
  assign bus.o_Row_Count   = row_q;
  assign bus.o_H_Sync      = flags_q.h_sync;
  assign bus.o_V_Sync      = flags_q.v_sync;
  assign bus.o_Frame_Start = flags_q.frame_start;

endmodule
